// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter: owner encodings,
// the read-request write-enable code and the wait-counter type.
package bram_port_arbiter_pkg;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } owner_t;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam int         WAIT_W  = 8;

  typedef logic [WAIT_W-1:0] wait_t;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic wait_t wait_inc(input wait_t v);
    return (v == '1) ? v : v + wait_t'(1);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a starvation override. Keeps the
// last owner and one saturating refusal counter per requester. hold1
// restricts the normal (non-override) grant to requester 1 only.
module rr_arb2
  import bram_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clka,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic hold1,
  output logic gnt0,
  output logic gnt1,
  output logic starve
);

  localparam wait_t WAIT_LIMIT = wait_t'(MAX_WAIT);

  owner_t last_owner;
  wait_t  wait0;
  wait_t  wait1;
  logic   starving0;
  logic   starving1;
  owner_t rr_pick;

  // Grant decision: starvation first, then the lock hold, then round-robin.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    starve    = 1'b0;
    starving0 = req0 && (wait0 >= WAIT_LIMIT);
    starving1 = req1 && (wait1 >= WAIT_LIMIT);
    rr_pick   = (last_owner == ARB_M0) ? ARB_M1 : ARB_M0;
    // Nothing is granted while reset is held so the RAM never sees a write.
    if (!rst) begin
      if (starving0 && starving1) begin
        starve = 1'b1;
        gnt0   = (rr_pick == ARB_M0);
        gnt1   = (rr_pick == ARB_M1);
      end else if (starving0) begin
        starve = 1'b1;
        gnt0   = 1'b1;
      end else if (starving1) begin
        starve = 1'b1;
        gnt1   = 1'b1;
      end else if (hold1) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        gnt0 = (rr_pick == ARB_M0);
        gnt1 = (rr_pick == ARB_M1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Track the last owner and count refused cycles per requester.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      last_owner <= ARB_M1;
      wait0      <= '0;
      wait1      <= '0;
    end else begin
      if (gnt0) begin
        last_owner <= ARB_M0;
      end else if (gnt1) begin
        last_owner <= ARB_M1;
      end
      if (gnt0) begin
        wait0 <= '0;
      end else if (req0) begin
        wait0 <= wait_inc(wait0);
      end
      if (gnt1) begin
        wait1 <= '0;
      end else if (req1) begin
        wait1 <= wait_inc(wait1);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block RAM between a CPU bridge (m0) and a DMA/loader (m1).
// One access per cycle; reads return one cycle later with a valid strobe
// to the requester that issued them. m1 may lock the RAM for bursts; the
// starvation override bounds how long m0 can be shut out.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [3:0]            m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic [3:0]            m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  input  logic                  m1_lock,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [3:0]            ram_wea,
  output logic [31:0]           ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb,
  output logic                  starve_evt
);

  logic   lock_owner_valid;
  logic   rd_pending;
  owner_t rd_owner;
  logic   arb_starve;
  logic   rd_grant;
  owner_t rd_grant_owner;

  rr_arb2 #(
    .MAX_WAIT(MAX_WAIT)
  ) u_rr_arb2 (
    .clka  (clka),
    .rst   (rst),
    .req0  (m0_req),
    .req1  (m1_req),
    .hold1 (lock_owner_valid),
    .gnt0  (m0_gnt),
    .gnt1  (m1_gnt),
    .starve(arb_starve)
  );

  // Steer the granted requester onto the RAM ports; idle ports follow m0.
  always_comb begin
    ram_addra      = m0_addr;
    ram_dina       = m0_wdata;
    ram_wea        = WE_READ;
    ram_addrb      = m0_addr;
    rd_grant       = 1'b0;
    rd_grant_owner = ARB_M0;
    if (m1_gnt) begin
      if (m1_we != WE_READ) begin
        ram_addra = m1_addr;
        ram_dina  = m1_wdata;
        ram_wea   = m1_we;
      end else begin
        ram_addrb      = m1_addr;
        rd_grant       = 1'b1;
        rd_grant_owner = ARB_M1;
      end
    end else if (m0_gnt) begin
      if (m0_we != WE_READ) begin
        ram_wea = m0_we;
      end else begin
        rd_grant = 1'b1;
      end
    end
  end

  // Lock state, read-return tracking and the starvation pulse.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      lock_owner_valid <= 1'b0;
      rd_pending       <= 1'b0;
      rd_owner         <= ARB_M0;
      starve_evt       <= 1'b0;
    end else begin
      // An override always breaks the lock, even if m1 asks to keep it.
      if (arb_starve) begin
        lock_owner_valid <= 1'b0;
      end else if (m1_gnt && m1_lock) begin
        lock_owner_valid <= 1'b1;
      end else if (!m1_lock) begin
        lock_owner_valid <= 1'b0;
      end
      rd_pending <= rd_grant;
      rd_owner   <= rd_grant_owner;
      starve_evt <= arb_starve;
    end
  end

  assign m0_rvalid = rd_pending && (rd_owner == ARB_M0);
  assign m1_rvalid = rd_pending && (rd_owner == ARB_M1);
  assign m0_rdata  = ram_doutb;
  assign m1_rdata  = ram_doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter with a behavioural RAM and a
// cycle-level reference model of the grant rules and read returns.
module tb_bram_port_arbiter;

  localparam int AW    = 6;
  localparam int MW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m1_lock;
  logic [3:0]    m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, starve_evt;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_dina, ram_doutb;

  always #5 clka = ~clka;

  bram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .MAX_WAIT  (MW)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_lock   (m1_lock),
    .ram_addra (ram_addra),
    .ram_wea   (ram_wea),
    .ram_dina  (ram_dina),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .starve_evt(starve_evt)
  );

  function automatic logic [31:0] init_val(input int k);
    if (k == 16) return 32'hDEADBEEF;
    if (k == 3) return 32'h11223344;
    return 32'h5A5A0000 ^ (32'(k) * 32'h01010101);
  endfunction

  // Behavioural read-first block RAM with byte enables.
  logic        preload;
  logic [31:0] ram [DEPTH];
  always @(posedge clka) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= init_val(k);
    end else begin
      ram_doutb <= ram[ram_addrb];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) ram[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
  end

  // Requester-side state.
  logic          r_req   [2];
  logic [3:0]    r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [31:0]   r_wdata [2];
  assign m0_req = r_req[0];   assign m1_req = r_req[1];
  assign m0_we = r_we[0];     assign m1_we = r_we[1];
  assign m0_addr = r_addr[0]; assign m1_addr = r_addr[1];
  assign m0_wdata = r_wdata[0]; assign m1_wdata = r_wdata[1];

  // Reference model state.
  int          m_last;
  bit          m_lock;
  int          m_wait [2];
  bit          e_rv   [2];
  bit          e_starve;
  logic [31:0] e_rdata;
  logic [31:0] shadow [DEPTH];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_lock = 0;
    m_wait[0] = 0; m_wait[1] = 0;
    e_rv[0] = 0; e_rv[1] = 0;
    e_starve = 0;
  endtask

  task automatic issue(input int i, input logic [3:0] we, input int addr, input logic [31:0] wd);
    r_req[i]   = 1'b1;
    r_we[i]    = we;
    r_addr[i]  = addr[AW-1:0];
    r_wdata[i] = wd;
  endtask

  task automatic rand_issue(input int i);
    if (!r_req[i] && $urandom_range(0, 99) < 60) begin
      if ($urandom_range(0, 1) == 1)
        issue(i, 4'($urandom_range(1, 15)), int'($urandom_range(0, DEPTH-1)), $urandom);
      else
        issue(i, 4'b0000, int'($urandom_range(0, DEPTH-1)), 32'h0);
    end
  endtask

  // One clock: predict grants, compare all outputs, advance the model.
  task automatic cycle();
    bit g [2];
    bit s [2];
    bit ov;
    int win;
    logic [3:0]  exp_wea;
    logic [31:0] old;
    @(negedge clka);
    g[0] = 0; g[1] = 0; ov = 0;
    for (int i = 0; i < 2; i++) s[i] = r_req[i] && (m_wait[i] >= MW);
    win = (m_last == 0) ? 1 : 0;
    if (s[0] && s[1]) begin ov = 1; g[win] = 1; end
    else if (s[0]) begin ov = 1; g[0] = 1; end
    else if (s[1]) begin ov = 1; g[1] = 1; end
    else if (m_lock) g[1] = r_req[1];
    else if (r_req[0] && r_req[1]) g[win] = 1;
    else begin g[0] = r_req[0]; g[1] = r_req[1]; end

    chk("m0_gnt", 32'(m0_gnt), 32'(g[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(g[1]));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    chk("starve_evt", 32'(starve_evt), 32'(e_starve));
    if (e_rv[0]) chk("m0_rdata", m0_rdata, e_rdata);
    if (e_rv[1]) chk("m1_rdata", m1_rdata, e_rdata);
    exp_wea = 4'b0000;
    for (int i = 0; i < 2; i++) if (g[i]) exp_wea = r_we[i];
    chk("ram_wea", 32'(ram_wea), 32'(exp_wea));

    e_rv[0] = 0; e_rv[1] = 0;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        if (r_we[i] == 4'b0000) begin
          chk("ram_addrb", 32'(ram_addrb), 32'(r_addr[i]));
          e_rv[i] = 1;
          e_rdata = shadow[r_addr[i]];
          $display("txn m%0d read  addr=%h data=%h", i, r_addr[i], e_rdata);
        end else begin
          chk("ram_addra", 32'(ram_addra), 32'(r_addr[i]));
          chk("ram_dina", ram_dina, r_wdata[i]);
          old = shadow[r_addr[i]];
          for (int b = 0; b < 4; b++)
            if (r_we[i][b]) old[8*b +: 8] = r_wdata[i][8*b +: 8];
          shadow[r_addr[i]] = old;
          $display("txn m%0d write addr=%h we=%b data=%h", i, r_addr[i], r_we[i], r_wdata[i]);
        end
      end
    end
    e_starve = ov;
    if (ov) m_lock = 0;
    else if (g[1] && m1_lock) m_lock = 1;
    else if (!m1_lock) m_lock = 0;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) m_wait[i] = 0;
      else if (r_req[i] && m_wait[i] < 255) m_wait[i] = m_wait[i] + 1;
    end
    if (g[0]) m_last = 0;
    else if (g[1]) m_last = 1;

    @(posedge clka);
    #1;
    for (int i = 0; i < 2; i++) if (g[i]) r_req[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m1_lock = 1'b0;
    while ((r_req[0] || r_req[1]) && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(r_req[0] || r_req[1]), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; preload = 1'b1; m1_lock = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wdata[i] = 0;
    end
    for (int k = 0; k < DEPTH; k++) shadow[k] = init_val(k);
    model_reset();
    @(posedge clka); #1;
    preload = 1'b0;

    // Reset state: requests present but no grant may be given.
    issue(0, 4'b1111, 1, 32'h1); issue(1, 4'b1111, 2, 32'h2);
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_starve", 32'(starve_evt), 32'h0);
    r_req[0] = 0; r_req[1] = 0;
    rst = 1'b0;

    // Sole read of 0x10.
    issue(0, 4'b0000, 16, 0);
    cycle(); cycle();

    // Contest: both read every cycle.
    for (int c = 0; c < 6; c++) begin
      if (!r_req[0]) issue(0, 4'b0000, int'($urandom_range(0, DEPTH-1)), 0);
      if (!r_req[1]) issue(1, 4'b0000, int'($urandom_range(0, DEPTH-1)), 0);
      cycle();
    end
    drain();

    // Byte write then read back.
    issue(1, 4'b0100, 3, 32'h00AA0000);
    cycle();
    issue(1, 4'b0000, 3, 0);
    cycle(); cycle();
    chk("byte_merge", shadow[3], 32'h11AA3344);

    // Lock with m0 continuously requesting.
    m1_lock = 1'b1;
    issue(0, 4'b0000, 9, 0);
    for (int c = 0; c < 14; c++) begin
      if (!r_req[1]) issue(1, 4'b0000, int'($urandom_range(0, DEPTH-1)), 0);
      if (!r_req[0]) issue(0, 4'b0000, int'($urandom_range(0, DEPTH-1)), 0);
      cycle();
    end
    drain();

    // Reset asserted just after a read grant.
    issue(0, 4'b0000, 5, 0);
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_mid_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_mid_m1_rvalid", 32'(m1_rvalid), 32'h0);
    issue(0, 4'b0000, 7, 0); issue(1, 4'b0000, 8, 0);
    #1;
    chk("rst_mid_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_mid_m1_gnt", 32'(m1_gnt), 32'h0);
    @(posedge clka); #2;
    rst = 1'b0;
    model_reset();
    cycle(); cycle();
    drain();

    // Pipelined reads 0..3 from m0.
    for (int k = 0; k < 4; k++) begin
      issue(0, 4'b0000, k, 0);
      cycle();
    end
    cycle();

    // Random traffic with random locking.
    for (int c = 0; c < 400; c++) begin
      rand_issue(0);
      rand_issue(1);
      if ($urandom_range(0, 9) == 0) m1_lock = ~m1_lock;
      cycle();
    end
    drain();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
